// File: rtl/bp_error_collector_if.sv
// Bus bundle for the backward-pass error collector: BP strobe, gradient/activation
// inputs, masked error outputs and a debug view of the controller state.
interface bp_error_collector_if #(
    parameter int N    = 6,
    parameter int M    = 3,
    parameter int BITS = 16
);
    // Handshake: BP is a level sampled every edge and only acted on while idle
    // (there is no ready; busy=1 means a BP on this edge is dropped). valid is a
    // single-cycle pulse with no back-pressure: dZ_out is new in that cycle and
    // then holds until the next completed collection.
    logic                             BP;
    logic [M-1:0][N-1:0][BITS-1:0]    grad_in;
    logic [N-1:0][BITS-1:0]           act_in;
    logic [N-1:0][BITS-1:0]           dZ_out;
    logic                             valid;
    logic                             busy;
    logic [1:0]                       dbg_state;

    modport master (
        output BP,
        output grad_in,
        output act_in,
        input  dZ_out,
        input  valid,
        input  busy,
        input  dbg_state
    );

    modport slave (
        input  BP,
        input  grad_in,
        input  act_in,
        output dZ_out,
        output valid,
        output busy,
        output dbg_state
    );
endinterface

// File: rtl/bp_error_collector.sv
// Serially sums M downstream neurons' w*dZ terms per input (saturating Q8.8) and
// applies the ReLU derivative of the previous layer's activations.
module bp_error_collector #(
    parameter int N    = 6,
    parameter int M    = 3,
    parameter int BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bp_error_collector_if.slave  bus
);

    localparam int KW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_MASK = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [N-1:0][BITS-1:0]    acc_q, acc_d;
    logic [N-1:0][BITS-1:0]    dz_q, dz_d;
    logic                      valid_q, valid_d;

    // One extra bit of headroom; a sign/carry disagreement means the add wrapped.
    function automatic logic [BITS-1:0] sat_add(input logic [BITS-1:0] a,
                                                input logic [BITS-1:0] b);
        logic [BITS:0] s;
        s = {a[BITS-1], a} + {b[BITS-1], b};
        if (s[BITS] != s[BITS-1]) begin
            sat_add = s[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        end else begin
            sat_add = s[BITS-1:0];
        end
    endfunction

    function automatic logic act_positive(input logic [BITS-1:0] a);
        act_positive = !a[BITS-1] && (|a);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            dz_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            dz_q    <= dz_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        dz_d    = dz_q;
        valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.BP) begin
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_ACC;
                end
            end

            S_ACC: begin
                for (int i = 0; i < N; i++) begin
                    acc_d[i] = sat_add(acc_q[i], bus.grad_in[k_q][i]);
                end
                if (k_q == KW'(M - 1)) begin
                    k_d     = '0;
                    state_d = S_MASK;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            S_MASK: begin
                // ReLU derivative is taken as 0 at exactly zero activation.
                for (int i = 0; i < N; i++) begin
                    dz_d[i] = act_positive(bus.act_in[i]) ? acc_q[i] : '0;
                end
                valid_d = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.dZ_out    = dz_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bp_error_collector.sv
// Directed bench for bp_error_collector: latency, ReLU mask, saturation, busy
// ignore, reset abort, hold and back-to-back throughput.
module tb_bp_error_collector;

    localparam int N    = 6;
    localparam int M    = 3;
    localparam int BITS = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bp_error_collector_if #(.N(N), .M(M), .BITS(BITS)) bus ();

    bp_error_collector #(.N(N), .M(M), .BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_grads(input logic [BITS-1:0] v);
        for (int k = 0; k < M; k++)
            for (int i = 0; i < N; i++)
                bus.grad_in[k][i] = v;
    endtask

    task automatic set_acts(input logic [BITS-1:0] v);
        for (int i = 0; i < N; i++) bus.act_in[i] = v;
    endtask

    task automatic pulse_bp();
        bus.BP = 1'b1;
        tick();
        bus.BP = 1'b0;
    endtask

    // Returns how many edges after the current point valid took to appear (99 = never).
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!bus.valid && n < limit) begin
            tick();
            n++;
        end
        if (!bus.valid) n = 99;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.BP = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.BP = 1'b0;
        total++;
        if (bus.valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        total++;
        if (bus.dbg_state !== 2'd0) begin
            bad++; $display("FAIL reset_state got=%0d exp=0", bus.dbg_state);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (bus.dZ_out[i] !== 16'h0000) begin
                bad++; $display("FAIL reset_dz[%0d] got=%h exp=0000", i, bus.dZ_out[i]);
            end
        end
    endtask

    task automatic test_basic();
        int n;
        set_grads(16'h0100);
        set_acts(16'h0100);
        pulse_bp();
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL basic_busy_after_bp got=%b exp=1", bus.busy);
        end
        wait_valid(10, n);
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL basic_latency got=%0d exp=4", n);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL basic_busy_at_valid got=%b exp=0", bus.busy);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (bus.dZ_out[i] !== 16'h0300) begin
                bad++; $display("FAIL basic_dz[%0d] got=%h exp=0300", i, bus.dZ_out[i]);
            end
        end
        tick();
        total++;
        if (bus.valid !== 1'b0) begin
            bad++; $display("FAIL basic_valid_one_cycle got=%b exp=0", bus.valid);
        end
    endtask

    task automatic test_relu_mask();
        int n;
        logic [BITS-1:0] acts [N];
        logic [BITS-1:0] exp_dz [N];
        acts   = '{16'hFEEF, 16'h0000, 16'h0201, 16'h0100, 16'h0001, 16'h8000};
        exp_dz = '{16'h0000, 16'h0000, 16'h0300, 16'h0300, 16'h0300, 16'h0000};
        set_grads(16'h0100);
        for (int i = 0; i < N; i++) bus.act_in[i] = acts[i];
        pulse_bp();
        wait_valid(10, n);
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL relu_latency got=%0d exp=4", n);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (bus.dZ_out[i] !== exp_dz[i]) begin
                bad++; $display("FAIL relu_dz[%0d] got=%h exp=%h", i, bus.dZ_out[i], exp_dz[i]);
            end
        end
        tick();
    endtask

    task automatic test_saturation();
        int n;
        set_grads(16'h0100);
        bus.grad_in[0][0] = 16'h7000;
        bus.grad_in[1][0] = 16'h2000;
        bus.grad_in[2][0] = 16'hC000;
        bus.grad_in[0][1] = 16'h9000;
        bus.grad_in[1][1] = 16'h9000;
        bus.grad_in[2][1] = 16'h9000;
        set_acts(16'h0100);
        pulse_bp();
        wait_valid(10, n);
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL sat_latency got=%0d exp=4", n);
        end
        total++;
        if (bus.dZ_out[0] !== 16'h3FFF) begin
            bad++; $display("FAIL sat_pos_dz0 got=%h exp=3fff", bus.dZ_out[0]);
        end
        total++;
        if (bus.dZ_out[1] !== 16'h8000) begin
            bad++; $display("FAIL sat_neg_dz1 got=%h exp=8000", bus.dZ_out[1]);
        end
        total++;
        if (bus.dZ_out[2] !== 16'h0300) begin
            bad++; $display("FAIL sat_plain_dz2 got=%h exp=0300", bus.dZ_out[2]);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        int busy_cnt;
        int valid_cnt;
        int n;
        set_grads(16'h0100);
        set_acts(16'h0100);
        busy_cnt  = 0;
        valid_cnt = 0;
        pulse_bp();
        if (bus.busy) busy_cnt++;
        tick();
        if (bus.busy) busy_cnt++;
        bus.BP = 1'b1;
        tick();
        bus.BP = 1'b0;
        if (bus.busy) busy_cnt++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.busy) busy_cnt++;
            if (bus.valid) valid_cnt++;
        end
        total++;
        if (busy_cnt !== 4) begin
            bad++; $display("FAIL ignore_busy_cycles got=%0d exp=4", busy_cnt);
        end
        total++;
        if (valid_cnt !== 1) begin
            bad++; $display("FAIL ignore_valid_count got=%0d exp=1", valid_cnt);
        end
        total++;
        if (bus.dZ_out[3] !== 16'h0300) begin
            bad++; $display("FAIL ignore_dz3 got=%h exp=0300", bus.dZ_out[3]);
        end
        // BP raised in the valid cycle starts a fresh run with new terms.
        pulse_bp();
        wait_valid(10, n);
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL rebp_first_latency got=%0d exp=4", n);
        end
        set_grads(16'h0080);
        bus.BP = 1'b1;
        tick();
        bus.BP = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL rebp_accept_busy got=%b exp=1", bus.busy);
        end
        wait_valid(10, n);
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL rebp_second_latency got=%0d exp=4", n);
        end
        total++;
        if (bus.dZ_out[0] !== 16'h0180) begin
            bad++; $display("FAIL rebp_dz0 got=%h exp=0180", bus.dZ_out[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int valid_cnt;
        int n;
        set_grads(16'h0100);
        set_acts(16'h0100);
        pulse_bp();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy);
        end
        total++;
        if (bus.dZ_out !== '0) begin
            bad++; $display("FAIL abort_dz got=%h exp=0", bus.dZ_out);
        end
        valid_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.valid) valid_cnt++;
            tick();
        end
        total++;
        if (valid_cnt !== 0) begin
            bad++; $display("FAIL abort_valid_count got=%0d exp=0", valid_cnt);
        end
        set_grads(16'h0040);
        pulse_bp();
        wait_valid(10, n);
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL abort_rerun_latency got=%0d exp=4", n);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (bus.dZ_out[i] !== 16'h00C0) begin
                bad++; $display("FAIL abort_rerun_dz[%0d] got=%h exp=00c0", i, bus.dZ_out[i]);
            end
        end
        tick();
    endtask

    task automatic test_hold();
        int valid_cnt;
        valid_cnt = 0;
        set_grads(16'h1234);
        set_acts(16'h0000);
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.valid) valid_cnt++;
        end
        total++;
        if (valid_cnt !== 0) begin
            bad++; $display("FAIL hold_valid_count got=%0d exp=0", valid_cnt);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (bus.dZ_out[i] !== 16'h00C0) begin
                bad++; $display("FAIL hold_dz[%0d] got=%h exp=00c0", i, bus.dZ_out[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int waited;
        first  = -1;
        second = -1;
        set_grads(16'h0100);
        set_acts(16'h0100);
        bus.BP = 1'b1;
        tick();
        for (int s = 1; s <= 12; s++) begin
            tick();
            if (bus.valid) begin
                if (first < 0) first = s;
                else if (second < 0) second = s;
            end
        end
        bus.BP = 1'b0;
        total++;
        if (first !== 4) begin
            bad++; $display("FAIL b2b_first_valid got=%0d exp=4", first);
        end
        total++;
        if (second !== 9) begin
            bad++; $display("FAIL b2b_second_valid got=%0d exp=9", second);
        end
        waited = 0;
        while (bus.busy && waited < 10) begin
            tick();
            waited++;
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL b2b_drain_busy got=%b exp=0", bus.busy);
        end
        total++;
        if (bus.dZ_out[5] !== 16'h0300) begin
            bad++; $display("FAIL b2b_dz5 got=%h exp=0300", bus.dZ_out[5]);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        bus.BP = 1'b0;
        set_grads('0);
        set_acts('0);
        test_reset();
        test_basic();
        test_relu_mask();
        test_saturation();
        test_busy_ignore();
        test_reset_mid_run();
        test_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_error_collector.md
# bp_error_collector

Backward-pass error collector for a hidden layer of `Neuron_ReLU` units. On a backward-phase strobe it serially sums the per-neuron back-propagated terms (w·dZ, Q8.8) from M downstream neurons and applies the ReLU derivative of the previous layer's activations. It then presents one dZ word per previous-layer neuron with a one-cycle valid pulse. It sits between a layer's `W_out` buses and the `dZ_in` ports of the layer feeding it, and is sequenced by `ArchCTRL`'s BP strobes.

## Interface
- `N`, 6, terms per neuron (fan-in of the downstream layer = width of previous layer)
- `M`, 3, number of downstream neurons summed (M ≥ 1)
- `BITS`, 16, word width; signed two's-complement Q8.8

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `BP`  in  1  start strobe (from `ArchCTRL` BPH/BPO); sampled each edge
- `grad_in`  in  [M-1:0][N-1:0][BITS-1:0]  per-neuron back-propagated terms; `grad_in[k][i]` is neuron k's contribution to input i
- `act_in`  in  [N-1:0][BITS-1:0]  previous-layer forward outputs, used for the ReLU mask
- `dZ_out`  out  [N-1:0][BITS-1:0]  masked error per previous-layer neuron
- `valid`  out  1  one-cycle pulse: `dZ_out` updated
- `busy`  out  1  high while a collection is in progress

## Operation
- FSM states: IDLE, ACC, MASK.
- IDLE: on an edge with `BP`=1:
  - clear all N accumulators to 0
  - set index k=0
  - set `busy`=1, go to ACC.
- ACC: each edge, for all i, `acc[i] <= sat(acc[i] + grad_in[k][i])`, then k++.
  - After the edge using k=M-1, go to MASK.
  - Exactly M ACC edges.
- MASK: one edge.
  - `dZ_out[i] <= (act_in[i] > 0, signed) ? acc[i] : 0`.
  - `valid <= 1`, `busy <= 0`, go to IDLE.
- `valid` is cleared on every edge where it is not being set.
- Arithmetic:
  - Add is BITS+1-bit signed, then saturate.
  - Positive overflow gives 16'h7FFF; negative overflow gives 16'h8000.
  - Saturation is applied per add, not only at the end.
  - No rounding; Q8.8 is preserved, with no shift.
- `act_in[i]` equal to 0 or negative gives `dZ_out[i]` = 0 (derivative at 0 is 0).
- `BP` while `busy`=1 is ignored. No queueing, no restart.
- `BP` in the IDLE cycle where `valid`=1 is accepted normally.
- `dZ_out` holds its last value until the next MASK edge.
- `grad_in` must be stable from the `BP` edge through the last ACC edge. `act_in` must be stable at the MASK edge.

## Timing
- Reset: state IDLE, k=0, accumulators 0, `dZ_out` all 0, `valid`=0, `busy`=0.
  - Reset wins over `BP` on the same edge.
  - Reset in ACC or MASK aborts the collection. `valid` never fires for the aborted run.
- Edge e0 samples `BP`=1.
  - ACC edges are e1..eM; `busy`=1 after e0.
  - MASK edge is eM+1. After it, `dZ_out` is valid, `valid`=1 for exactly one cycle, and `busy`=0.
- Latency from `BP` sample to `valid` high is M+1 edges; M=3 gives 4 cycles.
- Back-to-back runs: `BP` held high continuously gives one run per M+2 cycles. It is re-accepted on the edge after MASK.

## Test plan
- Basic sum (M=3, N=6): `grad_in[k][i]`=16'h0100 for all k,i; `act_in` all 16'h0100; pulse `BP` -> 4 edges later `valid`=1 for 1 cycle, every `dZ_out`=16'h0300.
- ReLU mask: same grads; `act_in`={16'hFEEF, 16'h0000, 16'h0201, 16'h0100, 16'h0001, 16'h8000} (index 0..5) -> `dZ_out`={0, 0, 16'h0300, 16'h0300, 16'h0300, 0}.
- Signed/saturation:
  - input 0 gets grads 16'h7000, 16'h2000, 16'hC000 -> 16'h3FFF (clips at the 2nd add, then adds -0x4000).
  - input 1 gets 16'h9000 ×3 -> 16'h8000.
  - `act_in` positive for both.
- Busy/ignore: pulse `BP`, pulse again 2 cycles later -> single `valid`, `busy` high for exactly 4 cycles, result equals the first run. Then `BP` during the `valid` cycle -> second `valid` 4 cycles later.
- Reset mid-run: pulse `BP`, assert `rst` at edge e2 -> `busy`=0, `dZ_out`=0, no `valid` pulse. A new `BP` then completes normally with correct sums.
- Hold behaviour: after a run, change `grad_in`/`act_in` with no `BP` -> `dZ_out` unchanged, `valid` stays 0.
